// File: rtl/epoca_treino.sv
// rtl/epoca_treino.sv - one FP16 perceptron training step (2 inputs + bias, delta rule)
// Contains the FP16 multiply and add/subtract units used by the top-level datapath.

module fp16_mul (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] y
);
    logic              sa, sb, sy;
    logic [4:0]        ea, eb;
    logic [9:0]        fa, fb, mant;
    logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic              g, st, rnd;
    logic [21:0]       prod;
    logic [10:0]       mant_r;
    logic signed [7:0] exp_r;

    always_comb begin
        sa     = a[15];
        ea     = a[14:10];
        fa     = a[9:0];
        sb     = b[15];
        eb     = b[14:10];
        fb     = b[9:0];
        sy     = sa ^ sb;
        a_nan  = (ea == 5'h1f) && (fa != 10'h000);
        b_nan  = (eb == 5'h1f) && (fb != 10'h000);
        a_inf  = (ea == 5'h1f) && (fa == 10'h000);
        b_inf  = (eb == 5'h1f) && (fb == 10'h000);
        a_zero = (ea == 5'h00);
        b_zero = (eb == 5'h00);

        prod = {11'd0, 1'b1, fa} * {11'd0, 1'b1, fb};
        if (prod[21]) begin
            mant  = prod[20:11];
            g     = prod[10];
            st    = |prod[9:0];
            exp_r = $signed({3'b000, ea}) + $signed({3'b000, eb}) - 8'sd14;
        end else begin
            mant  = prod[19:10];
            g     = prod[9];
            st    = |prod[8:0];
            exp_r = $signed({3'b000, ea}) + $signed({3'b000, eb}) - 8'sd15;
        end
        rnd    = g & (st | mant[0]);
        mant_r = {1'b0, mant} + {10'd0, rnd};
        if (mant_r[10]) begin
            exp_r = exp_r + 8'sd1;
        end

        if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
            y = 16'h7E00;
        end else if (a_inf || b_inf) begin
            y = {sy, 5'h1f, 10'h000};
        end else if (a_zero || b_zero) begin
            y = 16'h0000;
        end else if (exp_r >= 8'sd31) begin
            y = {sy, 5'h1f, 10'h000};
        end else if (exp_r <= 8'sd0) begin
            y = {sy, 15'h0000};
        end else begin
            y = {sy, exp_r[4:0], mant_r[9:0]};
        end
    end
endmodule

module fp16_add (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        sub,
    output logic [15:0] y
);
    logic              sa, sb, sl, ss, eff_sub, cancel, sticky, g, st, rnd;
    logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [4:0]        ea, eb, el, es, dexp;
    logic [9:0]        fa, fb, fl, fs, mant;
    logic [13:0]       ml, ms, ms_sh, diff, norm;
    logic [14:0]       sum;
    logic [3:0]        lz;
    logic [10:0]       mant_r;
    logic signed [7:0] exp_n;

    always_comb begin
        sa     = a[15];
        ea     = a[14:10];
        fa     = a[9:0];
        sb     = b[15] ^ sub;
        eb     = b[14:10];
        fb     = b[9:0];
        a_nan  = (ea == 5'h1f) && (fa != 10'h000);
        b_nan  = (eb == 5'h1f) && (fb != 10'h000);
        a_inf  = (ea == 5'h1f) && (fa == 10'h000);
        b_inf  = (eb == 5'h1f) && (fb == 10'h000);
        a_zero = (ea == 5'h00);
        b_zero = (eb == 5'h00);

        if ({ea, fa} >= {eb, fb}) begin
            sl = sa; el = ea; fl = fa;
            ss = sb; es = eb; fs = fb;
        end else begin
            sl = sb; el = eb; fl = fb;
            ss = sa; es = ea; fs = fa;
        end

        // Three extra bits act as guard/round/sticky for the aligned operand
        dexp   = el - es;
        ml     = {1'b1, fl, 3'b000};
        ms     = {1'b1, fs, 3'b000};
        sticky = 1'b0;
        if (dexp >= 5'd14) begin
            ms_sh = 14'd1;
        end else begin
            ms_sh  = ms >> dexp;
            sticky = |(ms & ((14'd1 << dexp) - 14'd1));
        end
        ms_sh[0] = ms_sh[0] | sticky;

        eff_sub = sl ^ ss;
        exp_n   = $signed({3'b000, el});
        sum     = {1'b0, ml} + {1'b0, ms_sh};
        diff    = ml - ms_sh;
        lz      = 4'd0;
        for (int i = 0; i < 14; i++) begin
            if (diff[i]) begin
                lz = 4'(13 - i);
            end
        end
        cancel = eff_sub && (diff == 14'd0);

        if (!eff_sub) begin
            if (sum[14]) begin
                norm  = sum[14:1] | {13'd0, sum[0]};
                exp_n = exp_n + 8'sd1;
            end else begin
                norm = sum[13:0];
            end
        end else begin
            norm  = diff << lz;
            exp_n = exp_n - $signed({4'b0000, lz});
        end

        mant   = norm[12:3];
        g      = norm[2];
        st     = |norm[1:0];
        rnd    = g & (st | mant[0]);
        mant_r = {1'b0, mant} + {10'd0, rnd};
        if (mant_r[10]) begin
            exp_n = exp_n + 8'sd1;
        end

        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
            y = 16'h7E00;
        end else if (a_inf) begin
            y = {sa, 5'h1f, 10'h000};
        end else if (b_inf) begin
            y = {sb, 5'h1f, 10'h000};
        end else if (a_zero && b_zero) begin
            y = {sa & sb, 15'h0000};
        end else if (a_zero) begin
            y = {sb, eb, fb};
        end else if (b_zero) begin
            y = {sa, ea, fa};
        end else if (cancel) begin
            y = 16'h0000;
        end else if (exp_n >= 8'sd31) begin
            y = {sl, 5'h1f, 10'h000};
        end else if (exp_n <= 8'sd0) begin
            y = {sl, 15'h0000};
        end else begin
            y = {sl, exp_n[4:0], mant_r[9:0]};
        end
    end
endmodule

module epoca_treino #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] u,
    input  logic [WIDTH-1:0] w0,
    input  logic [WIDTH-1:0] w1,
    input  logic [WIDTH-1:0] w2,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] w0_aux,
    output logic [WIDTH-1:0] w1_aux,
    output logic [WIDTH-1:0] w2_aux
);
    logic [15:0] p1, p2, s1, s, y, e, ue, t1, t2, w0_n, w1_n, w2_n;
    logic        s_pos, s_nan;
    logic [15:0] result_d, result_q, w0_aux_d, w0_aux_q;
    logic [15:0] w1_aux_d, w1_aux_q, w2_aux_d, w2_aux_q;

    fp16_mul u_mul_p1 (.a(w1), .b(in1), .y(p1));
    fp16_mul u_mul_p2 (.a(w2), .b(in2), .y(p2));
    fp16_add u_add_s1 (.a(w0), .b(p1), .sub(1'b0), .y(s1));
    fp16_add u_add_s  (.a(s1), .b(p2), .sub(1'b0), .y(s));

    // A NaN sum carries sign 0 but must not fire the neuron
    always_comb begin
        s_nan = (s[14:10] == 5'h1f) && (s[9:0] != 10'h000);
        s_pos = !s[15] && (s[14:0] != 15'h0000) && !s_nan;
        y     = s_pos ? 16'h3C00 : 16'h0000;
    end

    fp16_add u_add_e  (.a(d), .b(y), .sub(1'b1), .y(e));
    fp16_mul u_mul_ue (.a(u), .b(e), .y(ue));
    fp16_mul u_mul_t1 (.a(ue), .b(in1), .y(t1));
    fp16_mul u_mul_t2 (.a(ue), .b(in2), .y(t2));
    fp16_add u_add_w0 (.a(w0), .b(ue), .sub(1'b0), .y(w0_n));
    fp16_add u_add_w1 (.a(w1), .b(t1), .sub(1'b0), .y(w1_n));
    fp16_add u_add_w2 (.a(w2), .b(t2), .sub(1'b0), .y(w2_n));

    always_comb begin
        result_d = y;
        w0_aux_d = w0_n;
        w1_aux_d = w1_n;
        w2_aux_d = w2_n;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result_q <= 16'h0000;
            w0_aux_q <= 16'h0000;
            w1_aux_q <= 16'h0000;
            w2_aux_q <= 16'h0000;
        end else begin
            result_q <= result_d;
            w0_aux_q <= w0_aux_d;
            w1_aux_q <= w1_aux_d;
            w2_aux_q <= w2_aux_d;
        end
    end

    assign result = result_q;
    assign w0_aux = w0_aux_q;
    assign w1_aux = w1_aux_q;
    assign w2_aux = w2_aux_q;
endmodule

// File: tb/tb_epoca_treino.sv
// tb/tb_epoca_treino.sv - directed-vector bench for epoca_treino

module tb_epoca_treino;
    logic        clk;
    logic        reset;
    logic [15:0] in1, in2, d, u, w0, w1, w2;
    logic [15:0] result, w0_aux, w1_aux, w2_aux;
    int          checks;
    int          failures;

    logic [15:0] or_x1 [4];
    logic [15:0] or_x2 [4];
    logic [15:0] or_d  [4];
    logic [0:19] or_res;

    epoca_treino dut (
        .clk    (clk),
        .reset  (reset),
        .in1    (in1),
        .in2    (in2),
        .d      (d),
        .u      (u),
        .w0     (w0),
        .w1     (w1),
        .w2     (w2),
        .result (result),
        .w0_aux (w0_aux),
        .w1_aux (w1_aux),
        .w2_aux (w2_aux)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check16(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [15:0] er, input logic [15:0] e0,
                             input logic [15:0] e1, input logic [15:0] e2);
        check16({tag, ".result"}, result, er);
        check16({tag, ".w0_aux"}, w0_aux, e0);
        check16({tag, ".w1_aux"}, w1_aux, e1);
        check16({tag, ".w2_aux"}, w2_aux, e2);
    endtask

    task automatic run_vec(input string tag,
                           input logic [15:0] v_w0, input logic [15:0] v_w1, input logic [15:0] v_w2,
                           input logic [15:0] v_in1, input logic [15:0] v_in2,
                           input logic [15:0] v_d, input logic [15:0] v_u,
                           input logic [15:0] er, input logic [15:0] e0,
                           input logic [15:0] e1, input logic [15:0] e2);
        w0 = v_w0; w1 = v_w1; w2 = v_w2;
        in1 = v_in1; in2 = v_in2; d = v_d; u = v_u;
        @(posedge clk);
        #1;
        check_all(tag, er, e0, e1, e2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        or_x1  = '{16'h0000, 16'h3C00, 16'h0000, 16'h3C00};
        or_x2  = '{16'h0000, 16'h0000, 16'h3C00, 16'h3C00};
        or_d   = '{16'h0000, 16'h3C00, 16'h3C00, 16'h3C00};
        or_res = 20'b0011_1101_1111_0111_0111;

        reset = 1'b1;
        w0 = 16'h3C00; w1 = 16'h4000; w2 = 16'hC000;
        in1 = 16'h3C00; in2 = 16'h3800; d = 16'h3C00; u = 16'h3800;
        #2;
        reset = 1'b0;
        #1;
        check_all("rst_immediate", 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all("rst_held", 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        w0 = 16'h0000; w1 = 16'h0000; w2 = 16'h0000;
        in1 = 16'h0000; in2 = 16'h0000; d = 16'h0000; u = 16'h0000;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_all("rst_release", 16'h0000, 16'h0000, 16'h0000, 16'h0000);

        //        tag          w0       w1       w2       in1      in2      d        u        result   w0_aux   w1_aux   w2_aux
        run_vec("no_error",  16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h3800, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        run_vec("learn_up",  16'h0000, 16'h0000, 16'h0000, 16'h3C00, 16'h0000, 16'h3C00, 16'h3800, 16'h0000, 16'h3800, 16'h3800, 16'h0000);
        run_vec("learn_dn",  16'h3800, 16'h3800, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h3800, 16'h3C00, 16'h0000, 16'h3800, 16'h0000);
        run_vec("neg_sum",   16'hBC00, 16'h3400, 16'h3400, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3800, 16'h0000, 16'hB800, 16'h3A00, 16'h3A00);
        run_vec("nan_sum",   16'h7E00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h3800, 16'h0000, 16'h7E00, 16'h0000, 16'h0000);
        run_vec("ovf_inf",   16'h7BFF, 16'h7BFF, 16'h0000, 16'h3C00, 16'h0000, 16'h3C00, 16'h0000, 16'h3C00, 16'h7BFF, 16'h7BFF, 16'h0000);
        run_vec("neg_zero",  16'h8000, 16'h8000, 16'h3C00, 16'h0000, 16'h0000, 16'h0000, 16'h3800, 16'h0000, 16'h0000, 16'h0000, 16'h3C00);
        run_vec("subnorm",   16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h3800, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        run_vec("tie_even",  16'hBC00, 16'h3C00, 16'hBC01, 16'h3C00, 16'h3C00, 16'h3C00, 16'h1000, 16'h0000, 16'hBBFF, 16'h3C00, 16'hBC00);
        run_vec("tie_up",    16'hC000, 16'h3C01, 16'h3C00, 16'h3C00, 16'h0000, 16'h3C00, 16'h1000, 16'h0000, 16'hC000, 16'h3C02, 16'h3C00);

        reset = 1'b0;
        #1;
        check16("loop_rst", result, 16'h0000);
        reset = 1'b1;
        w0 = 16'h0000; w1 = 16'h0000; w2 = 16'h0000; u = 16'h3800;
        for (int ep = 0; ep < 5; ep++) begin
            for (int k = 0; k < 4; k++) begin
                in1 = or_x1[k];
                in2 = or_x2[k];
                d   = or_d[k];
                @(posedge clk);
                #1;
                check16($sformatf("or_ep%0d_s%0d", ep + 1, k), result,
                        or_res[ep*4+k] ? 16'h3C00 : 16'h0000);
                w0 = w0_aux;
                w1 = w1_aux;
                w2 = w2_aux;
            end
        end
        check16("or_final_w0", w0, 16'h0000);
        check16("or_final_w1", w1, 16'h3800);
        check16("or_final_w2", w2, 16'h3800);

        in1 = or_x1[1]; in2 = or_x2[1]; d = or_d[1];
        @(posedge clk);
        #1;
        check_all("mid_epoch", 16'h3C00, 16'h0000, 16'h3800, 16'h3800);
        #2;
        reset = 1'b0;
        #1;
        check_all("mid_rst", 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        @(posedge clk);
        #1;
        check_all("mid_rst_held", 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        reset = 1'b1;
        run_vec("restart",   16'h0000, 16'h0000, 16'h0000, 16'h3C00, 16'h0000, 16'h3C00, 16'h3800, 16'h0000, 16'h3800, 16'h3800, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
